fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction-fetch stage directly upstream of the CPU frontend. It drives the instruction-memory address and absorbs the synchronous memory's read latency. Returned opcode/operand bytes are buffered in a small FIFO and presented to the frontend on a valid/ready handshake, each tagged with its PC. A redirect from branch/terminator resolution flushes all buffered and in-flight bytes and restarts fetch at a new PC.

Parameters:
DEPTH, 4, FIFO entries (bytes); power of two, >=2
MEM_LATENCY, 1, cycles from addr_i to valid din_i; >=1
PC_W, 16, address width
RESET_PC, 16'h0000, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_en  in  1  permits new fetch requests (frontend wakeup)
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  PC_W  restart address
addr_i  out  PC_W  instruction memory address
din_i  in  8  instruction memory read data
instr  out  8  head-of-queue byte
instr_pc  out  PC_W  address of head byte
instr_valid  out  1  head entry valid
instr_ready  in  1  frontend accepts head byte
occupancy  out  $clog2(DEPTH+1)  bytes currently buffered

Behaviour:
- Reset (rst high at posedge): fetch_pc=RESET_PC, FIFO empty, in-flight pipe cleared, occupancy=0, instr_valid=0. instr and instr_pc are don't-care while invalid. rst high mid-operation discards everything. No request issues in the rst cycle.
- addr_i = fetch_pc register, driven every cycle. Memory reads unconditionally; only tracked requests are kept.
- Request fire (cycle t): fetch_en & ~redirect_valid & (occupancy + inflight_ct < DEPTH).
  - On fire: fetch_pc <= fetch_pc+1, wrapping FFFF->0000.
  - A (valid, pc) token enters a MEM_LATENCY-deep shift pipe.
- Return (cycle t+MEM_LATENCY): a token exiting the pipe valid pushes {din_i, token pc} into the FIFO. The credit rule guarantees the push never overflows; overflow is an assertion failure.
- Credit: a pop frees its slot for request-fire evaluation in the next cycle only, never the same cycle. Sustained throughput is 1 byte/cycle when DEPTH >= MEM_LATENCY+2.
- Pop: instr_valid & instr_ready. Head advances next cycle.
- Simultaneous push and pop: occupancy unchanged, ordering preserved.
- FIFO full: instr_valid stays 1, and no request fires until a pop frees a slot.
- Empty: instr_valid=0. There is no same-cycle bypass from din_i to instr; a byte is visible no earlier than t+MEM_LATENCY+1.
- Redirect (cycle r):
  - A pop completing in cycle r still counts as consumed.
  - FIFO is emptied, all in-flight tokens are invalidated (including one returning in cycle r), and fetch_pc <= redirect_pc.
  - instr_valid=0 in cycle r+1.
  - The first request at redirect_pc may fire in cycle r+1, and its byte appears at r+1+MEM_LATENCY+1.
- Redirect has priority over rst=0 activity and fetch_en. Redirect and rst together: reset wins.
- fetch_en low: no new requests. In-flight tokens still complete and buffered bytes still drain.
- Outputs instr, instr_pc, instr_valid and occupancy come from registers only (no combinational path from instr_ready/redirect_valid).

Decomposition:
- Shared defines header: PC_W default and RESET_PC, alongside the existing op/register width defines.
- One natural sub-module: byte_fifo, a parameterised sync FIFO (data width 8+PC_W, depth DEPTH). It provides push, pop, flush, count and head outputs, with registered head and count.
- fetch_queue owns fetch_pc, the in-flight pipe and the credit logic.

Test Plan:
1. Reset, RESET_PC=0x0200, MEM_LATENCY=1, memory returns addr[7:0], fetch_en=1, instr_ready=1 -> first instr_valid at cycle 3 after rst release with instr=0x00, instr_pc=0x0200; then one byte/cycle with instr_pc 0x0201, 0x0202, ...
2. instr_ready=0, fetch_en=1 -> occupancy rises to 4 and saturates. addr_i holds 0x0204, never exceeds DEPTH outstanding; no overflow assertion. Release ready -> bytes 0x0200..0x0203 emerge in order.
3. Redirect to 0x1000 while 3 bytes are buffered and 1 is in flight -> next-cycle instr_valid=0, occupancy=0. The stale returning byte is dropped; the next valid head has instr_pc=0x1000.
4. Redirect in the same cycle as a pop -> the popped byte counts as consumed exactly once; no duplicate and no loss after the restart.
5. fetch_pc=0xFFFE, free-running -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000.
6. rst asserted mid-stream with occupancy=3 -> next cycle instr_valid=0, occupancy=0, addr_i=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths and defaults for the instruction-fetch queue and its buffer.
package fetch_queue_pkg;

  localparam int unsigned FQ_OP_W        = 8;
  localparam int unsigned FQ_PC_W        = 16;
  localparam int unsigned FQ_DEPTH       = 4;
  localparam int unsigned FQ_MEM_LATENCY = 1;
  localparam logic [15:0] FQ_RESET_PC    = 16'h0000;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered head entry, head-valid flag and count.
module byte_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned W     = FQ_OP_W + FQ_PC_W,
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          do_pop;

  assign do_pop     = pop & valid_q;
  assign head       = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;

  // Next pointers, count and the head entry as it will look after this cycle
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = valid_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      // The pushed entry becomes head when the queue is (or is about to be) empty
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  // Control and head registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  // Upstream credit accounting must never push into a full queue
  always_ff @(posedge clk) begin
    if (!rst && !flush && push && !do_pop) begin
      assert (count_q != CW'(DEPTH)) else $error("byte_fifo: push into full queue");
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential fetch addresses, tracks in-flight
// memory reads, buffers returned bytes with their PC and flushes on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned    DEPTH       = FQ_DEPTH,
  parameter int unsigned    MEM_LATENCY = FQ_MEM_LATENCY,
  parameter int unsigned    PC_W        = FQ_PC_W,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(FQ_RESET_PC),
  localparam int unsigned   OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    addr_i,
  input  logic [FQ_OP_W-1:0] din_i,
  output logic [FQ_OP_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int unsigned ENT_W = FQ_OP_W + PC_W;
  localparam int unsigned CR_W  = $clog2(DEPTH + MEM_LATENCY + 1);

  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [PC_W-1:0]        pipe_pc_q [MEM_LATENCY];
  logic [PC_W-1:0]        pipe_pc_d [MEM_LATENCY];
  logic [CR_W-1:0]        inflight_ct;
  logic                   credit_ok;
  logic                   fire;
  logic                   ret_valid;
  logic [PC_W-1:0]        ret_pc;
  logic                   pop;
  logic [ENT_W-1:0]       head;

  assign addr_i = fetch_pc_q;

  // Credit check uses only registered state, so a pop frees its slot next cycle
  always_comb begin
    inflight_ct = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_ct = inflight_ct + CR_W'(pipe_vld_q[i]);
    end
    credit_ok = (CR_W'(occupancy) + inflight_ct) < CR_W'(DEPTH);
    fire      = fetch_en & ~redirect_valid & credit_ok;
  end

  // Next fetch PC and in-flight token shift; redirect kills every token
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pipe_vld_d = '0;
    pipe_pc_d  = pipe_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (fire)       fetch_pc_d = fetch_pc_q + PC_W'(1);
    pipe_vld_d[0] = fire;
    pipe_pc_d[0]  = fetch_pc_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_pc_d[i]  = pipe_pc_q[i-1];
    end
    if (redirect_valid) pipe_vld_d = '0;
  end

  // Token leaving the pipe pairs with this cycle's memory data
  always_comb begin
    ret_valid = pipe_vld_q[MEM_LATENCY-1] & ~redirect_valid;
    ret_pc    = pipe_pc_q[MEM_LATENCY-1];
    pop       = instr_valid & instr_ready;
  end

  // Fetch PC and token-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pipe_vld_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Token PC payload; only meaningful alongside its valid bit
  always_ff @(posedge clk) begin
    pipe_pc_q <= pipe_pc_d;
  end

  byte_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (ret_valid),
    .push_data  ({din_i, ret_pc}),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (instr_valid),
    .count      (occupancy)
  );

  assign instr    = head[ENT_W-1 -: FQ_OP_W];
  assign instr_pc = head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle-exact vector table plus scoreboarded
// redirect/wrap sequences. Memory model returns addr[7:0] one cycle later.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] addr_i;
  logic [7:0]  din_i;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  occupancy;

  fetch_queue #(
    .DEPTH       (4),
    .MEM_LATENCY (1),
    .PC_W        (16),
    .RESET_PC    (16'h0200)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .addr_i         (addr_i),
    .din_i          (din_i),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, latency 1, contents = low address byte
  always @(posedge clk) din_i <= addr_i[7:0];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst, fen, rdy, rdv;
    logic [15:0] rpc;
    logic        chk, v;
    logic [15:0] pc;
    logic [2:0]  occ;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, f, y, d, input logic [15:0] rp,
                     input logic c, v, input logic [15:0] p,
                     input logic [2:0] o, input logic [15:0] a);
    vec_t t;
    t.rst = r; t.fen = f; t.rdy = y; t.rdv = d; t.rpc = rp;
    t.chk = c; t.v = v; t.pc = p; t.occ = o; t.addr = a;
    vecs.push_back(t);
  endtask

  // Scoreboard: expected PCs queued by the stimulus, consumed on each accept
  logic [15:0] exp_q[$];
  logic [15:0] e;
  bit          sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && !rst && instr_valid && instr_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra: got byte pc=0x%0h, expected no further byte", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(e));
        check("sb_instr", 32'(instr), 32'(e[7:0]));
      end
    end
  end

  task automatic drain();
    instr_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0;

    // Reset then free-running fetch with ready high
    add(1,1,1,0,'h0,    0,0,'h0,   0,'h0);
    add(0,1,1,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,1,0,'h0,    1,0,'h0,   0,'h0201);
    add(0,1,1,0,'h0,    1,1,'h0200,1,'h0202);
    add(0,1,1,0,'h0,    1,1,'h0201,1,'h0203);
    add(0,1,1,0,'h0,    1,1,'h0202,1,'h0204);
    // Backpressure: fill to DEPTH, hold, then release
    add(1,1,0,0,'h0,    0,0,'h0,   0,'h0);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0201);
    add(0,1,0,0,'h0,    1,1,'h0200,1,'h0202);
    add(0,1,0,0,'h0,    1,1,'h0200,2,'h0203);
    add(0,1,0,0,'h0,    1,1,'h0200,3,'h0204);
    add(0,1,0,0,'h0,    1,1,'h0200,4,'h0204);
    add(0,1,1,0,'h0,    1,1,'h0200,4,'h0204);
    add(0,1,1,0,'h0,    1,1,'h0201,3,'h0204);
    add(0,1,1,0,'h0,    1,1,'h0202,2,'h0205);
    add(0,1,1,0,'h0,    1,1,'h0203,2,'h0206);
    add(0,1,1,0,'h0,    1,1,'h0204,2,'h0207);
    // Redirect with 3 buffered and 1 returning
    add(1,1,0,0,'h0,    0,0,'h0,   0,'h0);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0201);
    add(0,1,0,0,'h0,    1,1,'h0200,1,'h0202);
    add(0,1,0,0,'h0,    1,1,'h0200,2,'h0203);
    add(0,1,0,1,'h1000, 1,1,'h0200,3,'h0204);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h1000);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h1001);
    add(0,1,0,0,'h0,    1,1,'h1000,1,'h1002);
    add(0,1,0,0,'h0,    1,1,'h1000,2,'h1003);
    // Reset mid-stream at occupancy 3, together with a redirect
    add(1,1,0,0,'h0,    0,0,'h0,   0,'h0);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0201);
    add(0,1,0,0,'h0,    1,1,'h0200,1,'h0202);
    add(0,1,0,0,'h0,    1,1,'h0200,2,'h0203);
    add(1,1,0,1,'h5555, 1,1,'h0200,3,'h0204);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0201);
    // fetch_en low: in-flight completes, buffer drains, no new requests
    add(1,1,0,0,'h0,    0,0,'h0,   0,'h0);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0200);
    add(0,1,0,0,'h0,    1,0,'h0,   0,'h0201);
    add(0,0,0,0,'h0,    1,1,'h0200,1,'h0202);
    add(0,0,0,0,'h0,    1,1,'h0200,2,'h0202);
    add(0,0,0,0,'h0,    1,1,'h0200,2,'h0202);
    add(0,0,1,0,'h0,    1,1,'h0200,2,'h0202);
    add(0,0,1,0,'h0,    1,1,'h0201,1,'h0202);
    add(0,0,1,0,'h0,    1,0,'h0,   0,'h0202);

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      fetch_en       = vecs[i].fen;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].v));
        check($sformatf("v%0d_occ", i),   32'(occupancy),   32'(vecs[i].occ));
        check($sformatf("v%0d_addr", i),  32'(addr_i),      32'(vecs[i].addr));
        if (vecs[i].v) begin
          check($sformatf("v%0d_pc", i),    32'(instr_pc), 32'(vecs[i].pc));
          check($sformatf("v%0d_instr", i), 32'(instr),    32'(vecs[i].pc[7:0]));
        end
      end
      @(posedge clk); #1;
    end

    // Redirect in the same cycle as a pop: popped byte consumed exactly once
    rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_on = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (occupancy >= 3'd2) break;
      end
      check("t4_fill", 32'(k < 20), 32'd1);
    end
    exp_q.push_back(16'h0200);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h3000;
    @(posedge clk); #1;
    instr_ready = 1'b0; redirect_valid = 1'b0;
    check("t4_valid_after", 32'(instr_valid), 32'd0);
    check("t4_occ_after",   32'(occupancy),   32'd0);
    check("t4_addr_after",  32'(addr_i),      32'h3000);
    for (int j = 0; j < 6; j++) exp_q.push_back(16'h3000 + 16'(j));
    drain();
    check("t4_accepts", 32'(n_acc), 32'd7);

    // PC wrap across FFFF -> 0000
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    drain();
    check("t5_accepts", 32'(n_acc), 32'd11);
    sb_on = 1'b0;

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
